// File: rtl/mips_cpu_regfile_pkg.sv
// Shared constants and byte-lane merge helpers for the multi-port MIPS register file.
// Helpers work on the widest supported word; callers cast to and from their own width.
package mips_cpu_regfile_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MAX_NB     = 32;
  localparam int unsigned MAX_DATA_W = MAX_NB * BYTE_W;

  typedef logic [MAX_NB-1:0]     be_t;
  typedef logic [MAX_DATA_W-1:0] word_t;

  // Expand each byte enable into a full byte of mask bits.
  function automatic word_t be_to_mask(input be_t be);
    word_t m;
    m = '0;
    for (int i = 0; i < int'(MAX_NB); i++) begin
      m[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
    end
    return m;
  endfunction

  // Enabled lanes come from new_w; all other lanes keep old_w.
  function automatic word_t merge(input word_t old_w, input word_t new_w, input be_t be);
    word_t m;
    m = be_to_mask(be);
    return (new_w & m) | (old_w & ~m);
  endfunction

endpackage

// File: rtl/mips_cpu_regfile_scoreboard.sv
// Per-register busy bits: decode claims a destination, writeback releases it.
// A claim beats a same-cycle release; claiming an already-busy register pulses claim_conflict.
module mips_cpu_regfile_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_addr,
  input  logic                rel_en,
  input  logic [AW-1:0]       rel_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic                claim_conflict
);

  logic [NUM_REGS-1:0] busy_d, busy_q;
  logic                conflict_d, conflict_q;

  always_comb begin
    busy_d     = busy_q;
    conflict_d = 1'b0;
    if (rel_en) begin
      busy_d[rel_addr] = 1'b0;
    end
    if (claim_en) begin
      busy_d[claim_addr] = 1'b1;
      conflict_d         = busy_q[claim_addr];
    end
    // r0 never holds a pending result
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign busy           = busy_q;
  assign claim_conflict = conflict_q;

endmodule

// File: rtl/mips_cpu_register_file_mp.sv
// Multi-read-port MIPS register file with byte-lane writes, optional write bypass
// and a busy scoreboard for multicycle loads.
module mips_cpu_register_file_mp
  import mips_cpu_regfile_pkg::*;
#(
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned NUM_REGS   = 32,
  parameter  int unsigned READ_PORTS = 2,
  parameter  int unsigned BYPASS     = 1,
  parameter  int unsigned DEBUG_REG  = 2,
  localparam int unsigned AW         = $clog2(NUM_REGS),
  localparam int unsigned NB         = DATA_W / BYTE_W
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [READ_PORTS*AW-1:0]     rd_addr,
  output logic [READ_PORTS*DATA_W-1:0] rd_data,
  output logic [READ_PORTS-1:0]        rd_busy,
  input  logic                         wr_en,
  input  logic [AW-1:0]                wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic [NB-1:0]                wr_be,
  input  logic                         wr_release,
  input  logic                         claim_en,
  input  logic [AW-1:0]                claim_addr,
  output logic                         claim_conflict,
  output logic                         stall,
  output logic [DATA_W-1:0]            dbg_data
);

  localparam logic [AW-1:0] DBG_ADDR = AW'(DEBUG_REG);

  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   wr_merged;
  logic                wr_live;
  logic                byp_live;
  logic [NUM_REGS-1:0] busy;

  assign wr_live = wr_en && (wr_addr != '0);
  // Bypass is gated by reset so reads stay zero while reset is held.
  assign byp_live = (BYPASS != 0) && wr_live && reset_n;

  always_comb begin
    wr_merged = DATA_W'(merge(MAX_DATA_W'(regs_q[wr_addr]),
                              MAX_DATA_W'(wr_data),
                              MAX_NB'(wr_be)));
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_live) begin
      regs_d[wr_addr] = wr_merged;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar p = 0; p < int'(READ_PORTS); p++) begin : g_rd
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] word;

    assign addr = rd_addr[p*AW +: AW];

    always_comb begin
      word = regs_q[addr];
      if (byp_live && (addr == wr_addr)) begin
        word = wr_merged;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = word;
    assign rd_busy[p]                  = busy[addr];
  end

  assign stall = |rd_busy;

  always_comb begin
    dbg_data = regs_q[DBG_ADDR];
    if (byp_live && (wr_addr == DBG_ADDR)) begin
      dbg_data = wr_merged;
    end
  end

  mips_cpu_regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk            (clk),
    .reset_n        (reset_n),
    .claim_en       (claim_en),
    .claim_addr     (claim_addr),
    .rel_en         (wr_en && wr_release),
    .rel_addr       (wr_addr),
    .busy           (busy),
    .claim_conflict (claim_conflict)
  );

endmodule
